// File: rtl/ft_pkg.sv
// Shared definitions for the lockstep fault-tolerance blocks.
//   rec_state_e        : recovery controller state encoding
//   DEF_MAX_RETRY      : recoveries allowed before escalation to FATAL
//   DEF_CLEAN_COMMITS  : clean commits needed to forgive past recoveries
//   DEF_HALT_TIMEOUT   : cycles allowed for the cores to acknowledge halt
//   DEF_CNT_W          : width of the total-error counter
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_HALT         = 3'd1,
        ST_RESTORE      = 3'd2,
        ST_WAIT_RESTORE = 3'd3,
        ST_RESUME       = 3'd4,
        ST_FATAL        = 3'd5
    } rec_state_e;

    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_CLEAN_COMMITS = 16;
    localparam int DEF_HALT_TIMEOUT  = 64;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/lockstep_recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, count -> 0
//   clr   : synchronous clear (wins over inc)
//   inc   : increment by one, holds at all-ones
//   count : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/lockstep_recovery_ctrl.sv
// Recovery sequencer for a duplicated (lockstep) core pair.
// On a qualified comparator mismatch it halts both cores, waits for the
// halt acknowledge, pulses a checkpoint restore request, waits for the
// restore to finish and releases the cores. Repeated errors without a clean
// window, or cores that never acknowledge halt, end in a sticky FATAL state.
//   clk, reset         : clock and synchronous active-high reset
//   w_en1, w_en2       : register-file write enables of the two cores
//   error              : comparator mismatch flag
//   halt_ack           : both cores halted (level)
//   restore_done       : checkpoint restore complete (pulse)
//   halt               : stall request to both cores (registered)
//   restore_req        : one-cycle restore request (registered)
//   recovering         : recovery sequence in progress
//   fatal              : unrecoverable fault, sticky until reset (registered)
//   err_count          : saturating count of qualified errors
module lockstep_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int CLEAN_COMMITS = DEF_CLEAN_COMMITS,
    parameter int HALT_TIMEOUT  = DEF_HALT_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_en1,
    input  logic             w_en2,
    input  logic             error,
    input  logic             halt_ack,
    input  logic             restore_done,
    output logic             halt,
    output logic             restore_req,
    output logic             recovering,
    output logic             fatal,
    output logic [CNT_W-1:0] err_count
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int CLEAN_W = $clog2(CLEAN_COMMITS + 1);
    localparam int TMO_W   = $clog2(HALT_TIMEOUT + 1);

    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    // Terminal values are compared one step early so the action happens on
    // the edge where the count would reach its limit.
    localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLEAN_COMMITS - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(HALT_TIMEOUT - 1);

    rec_state_e         state_reg, state_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic               halt_reg, halt_next;
    logic               restore_req_reg, restore_req_next;
    logic               fatal_reg, fatal_next;
    logic [CLEAN_W-1:0] clean_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic any_wen, qerr, commit, in_idle, qerr_idle, commit_idle, clean_wrap;

    assign any_wen     = w_en1 | w_en2;
    assign qerr        = error & any_wen;
    assign commit      = any_wen & ~error;
    assign in_idle     = (state_reg == ST_IDLE);
    assign qerr_idle   = in_idle & qerr;
    assign commit_idle = in_idle & commit;
    assign clean_wrap  = commit_idle & (clean_cnt == CLEAN_LAST);

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        case (state_reg)
            ST_IDLE: begin
                if (qerr) begin
                    state_next = (retry_reg >= RETRY_MAX) ? ST_FATAL : ST_HALT;
                    if (retry_reg != RETRY_MAX) begin
                        retry_next = retry_reg + RETRY_W'(1);
                    end
                end else if (clean_wrap) begin
                    retry_next = '0;
                end
            end
            ST_HALT: begin
                if (halt_ack) begin
                    state_next = ST_RESTORE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ST_FATAL;
                end
            end
            ST_RESTORE:      state_next = ST_WAIT_RESTORE;
            ST_WAIT_RESTORE: if (restore_done) state_next = ST_RESUME;
            ST_RESUME:       state_next = ST_IDLE;
            ST_FATAL:        state_next = ST_FATAL;
            // An illegal encoding means corrupted control state; fail safe.
            default:         state_next = ST_FATAL;
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register, with no input-to-output path.
        halt_next        = (state_next == ST_HALT) || (state_next == ST_RESTORE) ||
                           (state_next == ST_WAIT_RESTORE) || (state_next == ST_FATAL);
        restore_req_next = (state_next == ST_RESTORE);
        fatal_next       = (state_next == ST_FATAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            retry_reg       <= '0;
            halt_reg        <= 1'b0;
            restore_req_reg <= 1'b0;
            fatal_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            retry_reg       <= retry_next;
            halt_reg        <= halt_next;
            restore_req_reg <= restore_req_next;
            fatal_reg       <= fatal_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (qerr_idle),
        .count (err_count)
    );

    // A qualified error restarts the clean window; reaching the window
    // length forgives past recoveries and restarts counting.
    sat_counter #(.W(CLEAN_W)) u_clean_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (qerr_idle | clean_wrap),
        .inc   (commit_idle),
        .count (clean_cnt)
    );

    // Counts HALT cycles; held at zero outside HALT so every halt attempt
    // starts a fresh timeout window.
    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_next != ST_HALT),
        .inc   (state_reg == ST_HALT),
        .count (tmo_cnt)
    );

    assign halt        = halt_reg;
    assign restore_req = restore_req_reg;
    assign fatal       = fatal_reg;
    assign recovering  = (state_reg == ST_HALT) || (state_reg == ST_RESTORE) ||
                         (state_reg == ST_WAIT_RESTORE) || (state_reg == ST_RESUME);

endmodule

// File: doc/lockstep_recovery_ctrl.md
Name: lockstep_recovery_ctrl

Overview:
- Sequences recovery of the duplicated-core pair whenever the register-file write comparator flags a mismatch.
- Samples the comparator's error and both write enables, and halts both cores.
- Requests a checkpoint restore, then resumes the cores.
- Escalates to a sticky fatal state after repeated errors or an unresponsive halt. Sits between the comparator, the core halt/debug interface and the checkpoint unit.

Parameters:
MAX_RETRY, 3, recoveries allowed before FATAL without an intervening clean window (>=1)
CLEAN_COMMITS, 16, consecutive error-free commits that clear the retry count (>=1)
HALT_TIMEOUT, 64, cycles to wait for halt_ack before FATAL (>=2)
CNT_W, 16, width of the total-error counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
w_en1  in  1  core-1 register-file write enable
w_en2  in  1  core-2 register-file write enable
error  in  1  comparator mismatch flag
halt_ack  in  1  both cores halted (level)
restore_done  in  1  checkpoint restore complete (single-cycle pulse)
halt  out  1  stall request to both cores
restore_req  out  1  one-cycle restore request to checkpoint unit
recovering  out  1  high in any state other than IDLE/FATAL
fatal  out  1  unrecoverable fault, sticky until reset
err_count  out  CNT_W  total qualified errors, saturating

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, retry_cnt 0, clean_cnt 0, timeout counter 0.
- Reset mid-operation: takes effect at the next edge from any state, including FATAL. All outputs return to 0 that edge; no restore_req is emitted.
- Qualified error: qerr = error & (w_en1 | w_en2). It is sampled only in IDLE and ignored in every other state.
- Commit: commit = (w_en1 | w_en2) & ~error.
- err_count increments by 1 on each qualified error, saturating at all-ones. It is incremented even when that error triggers FATAL.
- State machine: IDLE, HALT, RESTORE, WAIT_RESTORE, RESUME, FATAL.
- IDLE:
  - qerr at edge N: halt=1 from N+1; retry_cnt++; clean_cnt cleared.
  - If retry_cnt had already reached MAX_RETRY, go to FATAL instead of HALT.
  - A commit without qerr increments clean_cnt. When clean_cnt reaches CLEAN_COMMITS, retry_cnt and clean_cnt are both cleared on that edge.
- HALT:
  - halt=1; the timeout counter increments each cycle.
  - halt_ack=1 -> RESTORE, timeout counter cleared.
  - The counter reaching HALT_TIMEOUT without halt_ack -> FATAL.
  - If halt_ack is already high on the first HALT cycle, RESTORE is entered on the next edge; minimum HALT dwell is 1 cycle.
- RESTORE: restore_req=1 for exactly one cycle; halt=1; unconditional -> WAIT_RESTORE.
- WAIT_RESTORE: halt=1; restore_done -> RESUME. No timeout. A restore_done arriving in any other state is ignored.
- RESUME: halt=0 for 1 cycle; -> IDLE. Error sampling resumes in IDLE.
- FATAL: halt=1, fatal=1, recovering=0; remains until reset.
- recovering is decoded from state: 1 in HALT, RESTORE, WAIT_RESTORE and RESUME.
- Output implementation: halt, restore_req and fatal are registered outputs (Moore), not combinational from inputs.
- Latency:
  - qerr -> halt: 1 cycle.
  - halt_ack -> restore_req: 1 cycle.
  - restore_done -> halt deassert: 1 cycle.
- Width rules:
  - retry_cnt width is $clog2(MAX_RETRY+1).
  - clean_cnt width is $clog2(CLEAN_COMMITS+1).
  - Timeout counter width is $clog2(HALT_TIMEOUT+1).
  - None of these counters wraps.

Decomposition:
- Shared package ft_pkg:
  - rec_state_e, the state enum above.
  - Default parameter constants for MAX_RETRY, CLEAN_COMMITS and HALT_TIMEOUT.
- One sub-module, sat_counter: a parameterised saturating up-counter with clear. It is reused for err_count, clean_cnt and the timeout counter.
- The FSM stays in the top module.

Test Plan:
- Reset, then w_en1=w_en2=1 with error=0 for 20 cycles -> halt=0, err_count=0, recovering=0; retry_cnt is cleared at the 16th commit.
- Single error with w_en1=1 at cycle 10, halt_ack at 13, restore_done at 16:
  - halt rises at 11; restore_req is high for cycle 14 only.
  - halt falls at 17; state is IDLE at 18; err_count=1.
- error=1 with w_en1=w_en2=0 -> ignored, err_count stays 0. A second error arriving during WAIT_RESTORE -> ignored.
- Four recoveries with fewer than 16 clean commits between them:
  - Recoveries 1-3 complete normally.
  - The 4th qualified error -> fatal=1 next cycle with halt=1; err_count=4.
  - The state stays FATAL for 100 cycles; reset clears everything.
- Error followed by halt_ack held low -> fatal=1 after 64 HALT cycles; restore_req never asserted.
- Reset asserted in WAIT_RESTORE -> next edge all outputs 0. A later restore_done pulse -> no effect.
